// File: rtl/tx_link_sequencer.sv
// ----------------------------------------------------------------------------
// tx_link_sequencer
//
// Symbol-level controller in front of the transmit lane. It drives the byte,
// K flag, enable and TxElecIdle inputs of the transmitter. Once per symbol
// period it does one of the following:
//   - leaves electrical idle with a preamble of COM symbols;
//   - forwards a requester byte (valid/ready) or fills with logical idle;
//   - inserts a periodic SKP ordered set (COM followed by SKP symbols);
//   - sends an EIOS (COM followed by three EIDL symbols) before going idle.
//
// Ports:
//   clk         in   system clock, shared with the transmitter
//   rst         in   synchronous, active-low reset
//   linkUp      in   1 = request active link, 0 = request electrical idle
//   reqValid    in   requester offers reqData/reqK
//   reqData     in   requester byte
//   reqK        in   requester byte is a control (K) symbol
//   reqReady    out  one-clk pulse: the offered byte was consumed this edge
//   txData      out  byte to the transmitter
//   txK         out  K flag to the transmitter
//   txEnb       out  transmitter enable
//   txElecIdle  out  transmitter electrical-idle request
//   state       out  FSM state (IDLE=0, WAKE=1, DATA=2, SKP=3, EIOS=4)
//
// Symbol boundaries: WAKE ends with one extra strobe that moves to DATA and
// emits logical idle without consuming a byte. The strobe after the last SKP
// symbol makes a full DATA decision directly, so SKP never costs an extra
// fill symbol and a pending linkUp drop turns straight into EIOS.
// ----------------------------------------------------------------------------
module tx_link_sequencer #(
    parameter int unsigned SYM_DIV      = 10,
    parameter int unsigned WAKE_COMS    = 4,
    parameter int unsigned SKP_INTERVAL = 118,
    parameter int unsigned SKP_LEN      = 3
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       linkUp,
    input  logic       reqValid,
    input  logic [7:0] reqData,
    input  logic       reqK,
    output logic       reqReady,
    output logic [7:0] txData,
    output logic       txK,
    output logic       txEnb,
    output logic       txElecIdle,
    output logic [2:0] state
);

    // 8b/10b symbol codes used by the ordered sets
    localparam logic [7:0] SymCom  = 8'hBC;
    localparam logic [7:0] SymSkp  = 8'h1C;
    localparam logic [7:0] SymEidl = 8'h7C;
    localparam logic [7:0] SymIdle = 8'h00;

    localparam int unsigned EiosLen = 3;

    localparam int unsigned SymCntW = (SYM_DIV > 1) ? $clog2(SYM_DIV) : 1;
    localparam int unsigned SkpTmrW = (SKP_INTERVAL > 0) ? $clog2(SKP_INTERVAL + 1) : 1;
    localparam int unsigned SubCntW = 8;

    localparam logic [SymCntW-1:0] SymLast  = SymCntW'(SYM_DIV - 1);
    localparam logic [SkpTmrW-1:0] SkpMax   = SkpTmrW'(SKP_INTERVAL);
    localparam logic [SubCntW-1:0] WakeLen  = SubCntW'(WAKE_COMS);
    localparam logic [SubCntW-1:0] SkpLen   = SubCntW'(SKP_LEN);
    localparam logic [SubCntW-1:0] EidlLen  = SubCntW'(EiosLen);

    typedef enum logic [2:0] {
        StIdle = 3'd0,
        StWake = 3'd1,
        StData = 3'd2,
        StSkp  = 3'd3,
        StEios = 3'd4
    } state_e;

    state_e              state_q, state_d;
    logic [SymCntW-1:0]  sym_cnt_q, sym_cnt_d;
    logic [SkpTmrW-1:0]  skp_timer_q, skp_timer_d;
    // symbols of the current ordered set already emitted
    logic [SubCntW-1:0]  sub_cnt_q, sub_cnt_d;
    logic [7:0]          tx_data_q, tx_data_d;
    logic                tx_k_q, tx_k_d;
    logic                tx_enb_q, tx_enb_d;
    logic                tx_eidle_q, tx_eidle_d;
    logic                req_ready_q, req_ready_d;

    logic                sym_strobe;
    logic                data_decide;
    logic                skp_due;

    always_comb begin
        sym_strobe  = (sym_cnt_q == SymLast);
        sym_cnt_d   = sym_strobe ? '0 : sym_cnt_q + 1'b1;
        skp_due     = (skp_timer_q >= SkpMax);

        state_d     = state_q;
        sub_cnt_d   = sub_cnt_q;
        skp_timer_d = skp_timer_q;
        tx_data_d   = tx_data_q;
        tx_k_d      = tx_k_q;
        tx_enb_d    = tx_enb_q;
        tx_eidle_d  = tx_eidle_q;
        req_ready_d = 1'b0;
        data_decide = 1'b0;

        if (sym_strobe) begin
            unique case (state_q)
                StIdle: begin
                    if (linkUp) begin
                        // the entry edge already carries the first COM
                        state_d    = StWake;
                        sub_cnt_d  = SubCntW'(1);
                        tx_data_d  = SymCom;
                        tx_k_d     = 1'b1;
                        tx_enb_d   = 1'b1;
                        tx_eidle_d = 1'b0;
                    end
                end

                StWake: begin
                    if (sub_cnt_q < WakeLen) begin
                        sub_cnt_d = sub_cnt_q + 1'b1;
                        tx_data_d = SymCom;
                        tx_k_d    = 1'b1;
                    end else begin
                        // linkUp is deliberately not looked at here
                        state_d     = StData;
                        skp_timer_d = '0;
                        tx_data_d   = SymIdle;
                        tx_k_d      = 1'b0;
                    end
                end

                StData: begin
                    data_decide = 1'b1;
                end

                StSkp: begin
                    if (sub_cnt_q < SkpLen) begin
                        sub_cnt_d = sub_cnt_q + 1'b1;
                        tx_data_d = SymSkp;
                        tx_k_d    = 1'b1;
                    end else begin
                        data_decide = 1'b1;
                    end
                end

                StEios: begin
                    if (sub_cnt_q < EidlLen) begin
                        sub_cnt_d = sub_cnt_q + 1'b1;
                        tx_data_d = SymEidl;
                        tx_k_d    = 1'b1;
                    end else begin
                        state_d    = StIdle;
                        tx_data_d  = SymIdle;
                        tx_k_d     = 1'b0;
                        tx_enb_d   = 1'b0;
                        tx_eidle_d = 1'b1;
                    end
                end

                default: begin
                    state_d    = StIdle;
                    tx_data_d  = SymIdle;
                    tx_k_d     = 1'b0;
                    tx_enb_d   = 1'b0;
                    tx_eidle_d = 1'b1;
                end
            endcase

            // Shared DATA decision: shutdown beats SKP, SKP beats data.
            if (data_decide) begin
                if (!linkUp) begin
                    state_d   = StEios;
                    sub_cnt_d = '0;
                    tx_data_d = SymCom;
                    tx_k_d    = 1'b1;
                end else if (skp_due) begin
                    state_d     = StSkp;
                    sub_cnt_d   = '0;
                    skp_timer_d = '0;
                    tx_data_d   = SymCom;
                    tx_k_d      = 1'b1;
                end else begin
                    state_d = StData;
                    // not due means below the limit, so +1 cannot overshoot
                    skp_timer_d = skp_timer_q + 1'b1;
                    if (reqValid) begin
                        tx_data_d   = reqData;
                        tx_k_d      = reqK;
                        req_ready_d = 1'b1;
                    end else begin
                        tx_data_d = SymIdle;
                        tx_k_d    = 1'b0;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= StIdle;
            sym_cnt_q   <= '0;
            skp_timer_q <= '0;
            sub_cnt_q   <= '0;
            tx_data_q   <= SymIdle;
            tx_k_q      <= 1'b0;
            tx_enb_q    <= 1'b0;
            tx_eidle_q  <= 1'b1;
            req_ready_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            sym_cnt_q   <= sym_cnt_d;
            skp_timer_q <= skp_timer_d;
            sub_cnt_q   <= sub_cnt_d;
            tx_data_q   <= tx_data_d;
            tx_k_q      <= tx_k_d;
            tx_enb_q    <= tx_enb_d;
            tx_eidle_q  <= tx_eidle_d;
            req_ready_q <= req_ready_d;
        end
    end

    assign reqReady   = req_ready_q;
    assign txData     = tx_data_q;
    assign txK        = tx_k_q;
    assign txEnb      = tx_enb_q;
    assign txElecIdle = tx_eidle_q;
    assign state      = state_q;

endmodule

// File: tb/tb_tx_link_sequencer.sv
// ----------------------------------------------------------------------------
// tb_tx_link_sequencer
//
// Bench for tx_link_sequencer. A symbol-level model (a queue of pending
// ordered-set symbols plus a DATA decision) predicts every output each cycle.
// Directed sequences pin the symbol stream with literal tables; a random
// phase then toggles linkUp, pulses reset and drives a random requester.
// ----------------------------------------------------------------------------
module tb_tx_link_sequencer;

    localparam int unsigned SYM_DIV      = 10;
    localparam int unsigned WAKE_COMS    = 4;
    localparam int unsigned SKP_INTERVAL = 4;
    localparam int unsigned SKP_LEN      = 3;

    localparam int AftDecide = 0;
    localparam int AftWake   = 1;
    localparam int AftIdle   = 2;

    logic       clk = 1'b0;
    logic       rst;
    logic       linkUp;
    logic       reqValid;
    logic [7:0] reqData;
    logic       reqK;
    logic       reqReady;
    logic [7:0] txData;
    logic       txK;
    logic       txEnb;
    logic       txElecIdle;
    logic [2:0] state;

    always #5 clk = ~clk;

    tx_link_sequencer #(
        .SYM_DIV     (SYM_DIV),
        .WAKE_COMS   (WAKE_COMS),
        .SKP_INTERVAL(SKP_INTERVAL),
        .SKP_LEN     (SKP_LEN)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .linkUp    (linkUp),
        .reqValid  (reqValid),
        .reqData   (reqData),
        .reqK      (reqK),
        .reqReady  (reqReady),
        .txData    (txData),
        .txK       (txK),
        .txEnb     (txEnb),
        .txElecIdle(txElecIdle),
        .state     (state)
    );

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    // model state
    bit          m_valid = 1'b0;
    int unsigned m_cnt;
    bit          m_active;
    logic [8:0]  m_q[$];
    int          m_after;
    int unsigned m_timer;
    logic [2:0]  m_state;
    logic [7:0]  m_data;
    logic        m_k, m_enb, m_eidle, m_ready;

    // observed symbols {state, enb, eidle, k, data}, one per strobe
    logic [13:0] sym_log[$];
    logic [13:0] exp_log[$];
    logic [8:0]  consumed[$];

    // requester
    bit          dir_mode;
    logic [7:0]  dir_bytes[$];
    int          offered = 0;
    int          taken   = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %h, want %h", name, got, want);
        end
    endtask

    task automatic model_reset();
        m_valid  = 1'b1;
        m_cnt    = 0;
        m_active = 1'b0;
        m_q.delete();
        m_after  = AftDecide;
        m_timer  = 0;
        m_state  = 3'd0;
        m_data   = 8'h00;
        m_k      = 1'b0;
        m_enb    = 1'b0;
        m_eidle  = 1'b1;
        m_ready  = 1'b0;
    endtask

    // One symbol period of the link, as the rules describe it.
    task automatic model_symbol();
        if (!m_active) begin
            if (linkUp) begin
                m_active = 1'b1;
                m_enb    = 1'b1;
                m_eidle  = 1'b0;
                m_state  = 3'd1;
                {m_k, m_data} = {1'b1, 8'hBC};
                for (int i = 1; i < int'(WAKE_COMS); i++) m_q.push_back({1'b1, 8'hBC});
                m_after = AftWake;
            end
        end else if (m_q.size() != 0) begin
            {m_k, m_data} = m_q.pop_front();
        end else if (m_after == AftWake) begin
            m_state = 3'd2;
            {m_k, m_data} = 9'h000;
            m_timer = 0;
            m_after = AftDecide;
        end else if (m_after == AftIdle) begin
            m_active = 1'b0;
            m_state  = 3'd0;
            {m_k, m_data} = 9'h000;
            m_enb    = 1'b0;
            m_eidle  = 1'b1;
            m_after  = AftDecide;
        end else if (!linkUp) begin
            m_state = 3'd4;
            {m_k, m_data} = {1'b1, 8'hBC};
            for (int i = 0; i < 3; i++) m_q.push_back({1'b1, 8'h7C});
            m_after = AftIdle;
        end else if (m_timer >= SKP_INTERVAL) begin
            m_state = 3'd3;
            {m_k, m_data} = {1'b1, 8'hBC};
            for (int i = 0; i < int'(SKP_LEN); i++) m_q.push_back({1'b1, 8'h1C});
            m_timer = 0;
        end else begin
            m_state = 3'd2;
            if (reqValid) begin
                {m_k, m_data} = {reqK, reqData};
                m_ready = 1'b1;
            end else begin
                {m_k, m_data} = 9'h000;
            end
            if (m_timer < SKP_INTERVAL) m_timer++;
        end
    endtask

    task automatic offer(input logic k, input logic [7:0] d);
        reqValid = 1'b1;
        reqK     = k;
        reqData  = d;
        offered++;
    endtask

    // Advance one clock: compare at the falling edge, then drive inputs.
    task automatic step();
        logic        strobe;
        logic [14:0] got, want;
        @(negedge clk);
        cyc++;
        strobe = 1'b0;
        if (!rst) begin
            model_reset();
        end else if (m_valid) begin
            m_ready = 1'b0;
            strobe  = (m_cnt == SYM_DIV - 1);
            m_cnt   = strobe ? 0 : m_cnt + 1;
            if (strobe) model_symbol();
        end
        if (m_valid) begin
            got  = {state, txEnb, txElecIdle, txK, txData, reqReady};
            want = {m_state, m_enb, m_eidle, m_k, m_data, m_ready};
            checks++;
            if (got !== want) begin
                errors++;
                $display("FAIL cycle %0d outputs: got st=%0d enb=%b eidle=%b k=%b data=%h rdy=%b, want st=%0d enb=%b eidle=%b k=%b data=%h rdy=%b",
                         cyc, state, txEnb, txElecIdle, txK, txData, reqReady,
                         m_state, m_enb, m_eidle, m_k, m_data, m_ready);
            end
            if (strobe) sym_log.push_back(got[14:1]);
            if (reqReady === 1'b1) consumed.push_back({txK, txData});
        end
        #1;
        if (reqValid && reqReady === 1'b1) begin
            taken++;
            reqValid = 1'b0;
            if (dir_mode && dir_bytes.size() != 0) offer(1'b0, dir_bytes.pop_front());
        end
        if (!dir_mode && !reqValid && $urandom_range(0, 3) == 0)
            offer($urandom_range(0, 7) == 0, 8'($urandom));
    endtask

    task automatic wait_log(input int n, input string name);
        int guard;
        guard = 0;
        while (sym_log.size() < n && guard < 40 * int'(SYM_DIV)) begin
            step();
            guard++;
        end
        if (sym_log.size() < n) begin
            checks++;
            errors++;
            $display("FAIL %s: timeout with %0d symbols, want %0d", name, sym_log.size(), n);
        end
    endtask

    task automatic add_exp(input logic [2:0] st, input logic enb, input logic eidle,
                           input logic k, input logic [7:0] d, input int reps);
        for (int i = 0; i < reps; i++) exp_log.push_back({st, enb, eidle, k, d});
    endtask

    task automatic check_log(input string name);
        logic [13:0] g;
        for (int i = 0; i < exp_log.size(); i++) begin
            g = (i < sym_log.size()) ? sym_log[i] : 14'h3fff;
            check($sformatf("%s sym%0d", name, i), 32'(g), 32'(exp_log[i]));
        end
    endtask

    task automatic check_idle_outputs(input string name);
        check({name, " txElecIdle"}, 32'(txElecIdle), 32'd1);
        check({name, " txEnb"}, 32'(txEnb), 32'd0);
        check({name, " txData"}, 32'(txData), 32'h00);
        check({name, " txK"}, 32'(txK), 32'd0);
        check({name, " state"}, 32'(state), 32'd0);
        check({name, " reqReady"}, 32'(reqReady), 32'd0);
    endtask

    initial begin
        int guard;
        bit found;
        rst      = 1'b0;
        linkUp   = 1'b0;
        reqValid = 1'b0;
        reqData  = 8'h00;
        reqK     = 1'b0;
        dir_mode = 1'b1;

        // reset, then idle with linkUp low
        repeat (3) step();
        check_idle_outputs("reset");
        rst = 1'b1;
        repeat (50) step();
        check_idle_outputs("idle after reset");

        // wake with no traffic, then drop linkUp exactly when SKP is due
        sym_log.delete();
        linkUp = 1'b1;
        wait_log(9, "wake1");
        linkUp = 1'b0;
        wait_log(14, "shutdown1");
        exp_log.delete();
        add_exp(3'd1, 1'b1, 1'b0, 1'b1, 8'hBC, 4);
        add_exp(3'd2, 1'b1, 1'b0, 1'b0, 8'h00, 5);
        add_exp(3'd4, 1'b1, 1'b0, 1'b1, 8'hBC, 1);
        add_exp(3'd4, 1'b1, 1'b0, 1'b1, 8'h7C, 3);
        add_exp(3'd0, 1'b0, 1'b1, 1'b0, 8'h00, 1);
        check_log("wake/eios");

        // handshake across a SKP, linkUp drop in SKP, linkUp rise in EIOS
        dir_bytes.push_back(8'h22);
        dir_bytes.push_back(8'h33);
        dir_bytes.push_back(8'h44);
        dir_bytes.push_back(8'h55);
        dir_bytes.push_back(8'h66);
        offer(1'b0, 8'h11);
        sym_log.delete();
        consumed.delete();
        linkUp = 1'b1;
        wait_log(18, "data/skp");
        linkUp = 1'b0;
        wait_log(23, "skp->eios");
        linkUp = 1'b1;
        wait_log(27, "rewake");
        exp_log.delete();
        add_exp(3'd1, 1'b1, 1'b0, 1'b1, 8'hBC, 4);
        add_exp(3'd2, 1'b1, 1'b0, 1'b0, 8'h00, 1);
        add_exp(3'd2, 1'b1, 1'b0, 1'b0, 8'h11, 1);
        add_exp(3'd2, 1'b1, 1'b0, 1'b0, 8'h22, 1);
        add_exp(3'd2, 1'b1, 1'b0, 1'b0, 8'h33, 1);
        add_exp(3'd2, 1'b1, 1'b0, 1'b0, 8'h44, 1);
        add_exp(3'd3, 1'b1, 1'b0, 1'b1, 8'hBC, 1);
        add_exp(3'd3, 1'b1, 1'b0, 1'b1, 8'h1C, 3);
        add_exp(3'd2, 1'b1, 1'b0, 1'b0, 8'h55, 1);
        add_exp(3'd2, 1'b1, 1'b0, 1'b0, 8'h66, 1);
        add_exp(3'd2, 1'b1, 1'b0, 1'b0, 8'h00, 2);
        add_exp(3'd3, 1'b1, 1'b0, 1'b1, 8'hBC, 1);
        add_exp(3'd3, 1'b1, 1'b0, 1'b1, 8'h1C, 3);
        add_exp(3'd4, 1'b1, 1'b0, 1'b1, 8'hBC, 1);
        add_exp(3'd4, 1'b1, 1'b0, 1'b1, 8'h7C, 3);
        add_exp(3'd0, 1'b0, 1'b1, 1'b0, 8'h00, 1);
        add_exp(3'd1, 1'b1, 1'b0, 1'b1, 8'hBC, 1);
        check_log("traffic");
        check("consumed count", 32'(consumed.size()), 32'd6);
        for (int i = 0; i < 6; i++) begin
            logic [8:0] c;
            c = (i < consumed.size()) ? consumed[i] : 9'h1ff;
            check($sformatf("consumed byte %0d", i), 32'(c), 32'(8'h11 * (i + 1)));
        end

        // reset in the middle of a SKP set
        guard = 0;
        found = 1'b0;
        while (!found && guard < 600) begin
            step();
            guard++;
            found = (sym_log.size() > 27) && (sym_log[sym_log.size() - 1][13:11] == 3'd3);
        end
        check("reach SKP before mid-SKP reset", 32'(found), 32'd1);
        rst = 1'b0;
        step();
        check_idle_outputs("reset mid-SKP");
        rst = 1'b1;

        // random traffic, link toggles and occasional resets
        dir_mode = 1'b0;
        for (int i = 0; i < 5000; i++) begin
            if ($urandom_range(0, 249) == 0) linkUp = ~linkUp;
            if (!rst) rst = 1'b1;
            else if ($urandom_range(0, 1999) == 0) rst = 1'b0;
            step();
        end
        check("bytes accounted", 32'((offered - taken) <= 1 && taken > 0), 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/tx_link_sequencer.md
Name: tx_link_sequencer

Overview:
Symbol-level controller placed ahead of the PCIe transmit lane (to8bit -> 8b/10b encoder -> parallel-serial -> differential emitter). It drives the byte, K flag, enable and TxElecIdle inputs of the transmitter.
- Exits electrical idle with a COM preamble.
- Forwards requester bytes through a valid/ready handshake, filling with logical idle when no byte is offered.
- Periodically inserts SKP ordered sets.
- Sends an EIOS (electrical idle ordered set) before returning to electrical idle.

Parameters:
SYM_DIV, 10, clk cycles per symbol; matches the clk10 divide of the serializer.
WAKE_COMS, 4, number of COM symbols sent after leaving electrical idle.
SKP_INTERVAL, 118, DATA-state symbols between SKP ordered sets.
SKP_LEN, 3, number of SKP symbols after the COM of each SKP set.

Ports:
clk  input  1  system clock, same clock as the transmitter.
rst  input  1  reset; synchronous, active-low.
linkUp  input  1  1 = request active link; 0 = request electrical idle.
reqValid  input  1  requester offers reqData/reqK.
reqData  input  8  requester byte.
reqK  input  1  requester byte is a control (K) symbol.
reqReady  output  1  one-clk pulse: offered byte consumed this cycle.
txData  output  8  byte to transmitter dataIn.
txK  output  1  to transmitter K.
txEnb  output  1  to transmitter enb.
txElecIdle  output  1  to transmitter TxElecIdle.
state  output  3  current FSM state (IDLE=0, WAKE=1, DATA=2, SKP=3, EIOS=4).

Behaviour:
Reset (rst==0 sampled at posedge clk):
- All registers clear on that edge: symCnt=0, skpTimer=0, state=IDLE.
- Outputs: txData=0, txK=0, txEnb=0, txElecIdle=1, reqReady=0.
- Reset asserted mid-operation aborts any ordered set immediately; no EIOS is sent.

Symbol timing:
- symCnt counts 0..SYM_DIV-1 and wraps. It runs whenever rst==1.
- symStrobe = (symCnt==SYM_DIV-1).
- FSM transitions and txData/txK/txEnb/txElecIdle updates occur only on the clk edge where symStrobe==1.
- All outputs are registered and hold their value for SYM_DIV cycles.

IDLE:
- Outputs as in reset.
- At a strobe with linkUp==1: go to WAKE; that same edge outputs txEnb=1, txElecIdle=0, first COM (txData=8'hBC, txK=1).

WAKE:
- Emits exactly WAKE_COMS COM symbols in total, counting the one issued on entry.
- At the next strobe: go to DATA and clear skpTimer.
- linkUp dropping during WAKE is ignored until DATA is reached.

DATA (decision priority at each strobe):
1. linkUp==0 -> EIOS: emit COM.
2. Else skpTimer>=SKP_INTERVAL -> SKP: emit COM, clear skpTimer.
3. Else reqValid==1 -> emit reqData/reqK; reqReady=1 for that single clk; skpTimer+1.
4. Else emit logical idle (8'h00, txK=0); skpTimer+1.

skpTimer rule: saturates at SKP_INTERVAL. It counts only in DATA.

Handshake:
- reqReady is asserted only in DATA, only on a strobe edge, and only when branch 3 fires.
- The requester holds reqValid/reqData/reqK stable until it sees reqReady.
- A byte is never dropped or duplicated.
- Latency: byte appears on txData on the same edge reqReady rises.

SKP:
- Emits SKP_LEN symbols of 8'h1C with txK=1 on consecutive strobes, then returns to DATA.
- A SKP set always completes even if linkUp falls during it; EIOS follows at the next DATA decision.
- reqReady stays 0 throughout.

EIOS:
- Emits 3 symbols of 8'h7C with txK=1 after the COM.
- At the next strobe: go to IDLE with txEnb=0, txElecIdle=1, txData=0, txK=0.
- linkUp returning high during EIOS takes effect only from IDLE.

Test Plan:
- Reset check: rst=0 for 3 clk -> txElecIdle=1, txEnb=0, txData=0, state=0. Release with linkUp=0 for 50 clk -> all outputs unchanged.
- Wake: raise linkUp -> at first strobe txEnb=1, txElecIdle=0. Four symbols 0xBC/K=1, each held 10 clk. Then state=2 and 0x00/K=0 fill.
- Handshake: in DATA, offer 0x11, 0x22, 0x33 (reqK=0), each held until reqReady -> exactly 3 single-clk reqReady pulses, 10 clk apart. txData shows 0x11, 0x22, 0x33 in order.
- SKP insertion: with SKP_INTERVAL=4 and reqValid=1 continuously -> after 4 data symbols: BC, 1C, 1C, 1C (K=1) with reqReady=0, then data resumes with no byte lost.
- Shutdown: drop linkUp in DATA -> BC, 7C, 7C, 7C (K=1), then txElecIdle=1, txEnb=0, state=0.
- Simultaneous events: linkUp drop at the same strobe as a SKP being due -> EIOS is sent, not SKP. linkUp drop during SKP -> SKP completes, then EIOS. rst=0 mid-SKP -> outputs reach reset values on the next edge.
